mem_write_checker: RTL and testbench



---
 rtl/mem_write_checker.sv | 183 ++++++++++++++++++
 tb/tb_mem_write_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops a memory-write bus and checks that a programmed
// sequence of (address, data) stores occurs, reporting pass/fail, the failure
// cause, the failing table entry and the number of cycles since arm.
module mem_write_checker #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned N_CHECKS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter bit          STRICT_ORDER   = 1'b0,
    parameter int unsigned IDX_W          = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
    input  logic              CLK,
    input  logic              NRESET,
    input  logic              Start,
    input  logic              Cfg_WE,
    input  logic [IDX_W-1:0]  Cfg_Idx,
    input  logic [ADDR_W-1:0] Cfg_Addr,
    input  logic [DATA_W-1:0] Cfg_Data,
    input  logic [IDX_W:0]    Cfg_Count,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic              Fail,
    output logic [1:0]        Fail_Code,
    output logic [IDX_W-1:0]  Fail_Index,
    output logic [31:0]       Cycle_Count
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned CYC_W = 32;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_UNEXP    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_PASSED = 2'd2,
        ST_FAILED = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [CYC_W-1:0]   w_cyc_nxt;
    logic [1:0]         r_code;
    logic [1:0]         w_code_nxt;
    logic [IDX_W-1:0]   r_fidx;
    logic [IDX_W-1:0]   w_fidx_nxt;

    logic [ADDR_W-1:0]  r_exp_addr [N_CHECKS];
    logic [DATA_W-1:0]  r_exp_data [N_CHECKS];

    logic [CNT_W-1:0]   w_count_clamp;
    logic [CYC_W-1:0]   w_cyc_inc;
    logic               w_addr_hit;
    logic               w_data_hit;
    logic               w_last;
    logic               w_timeout;
    logic               w_terminal;
    logic               w_cfg_ok;

    // Shared decode of the current entry, cycle counter and start count
    always_comb begin
        w_count_clamp = (Cfg_Count > CNT_W'(N_CHECKS)) ? CNT_W'(N_CHECKS) : Cfg_Count;
        w_cyc_inc     = (r_cyc == '1) ? r_cyc : r_cyc + CYC_W'(1);
        w_addr_hit    = (Address == r_exp_addr[r_ptr]);
        w_data_hit    = (Write_Data == r_exp_data[r_ptr]);
        w_last        = ((CNT_W'(r_ptr) + CNT_W'(1)) == r_count);
        w_timeout     = (w_cyc_inc >= CYC_W'(TIMEOUT_CYCLES));
        w_cfg_ok      = Cfg_WE && (r_state != ST_ARMED)
                        && (CNT_W'(Cfg_Idx) < CNT_W'(N_CHECKS));
    end

    // Next-state and datapath update; store evaluation takes precedence over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_cyc_nxt   = r_cyc;
        w_code_nxt  = r_code;
        w_fidx_nxt  = r_fidx;
        w_terminal  = 1'b0;
        case (r_state)
            ST_ARMED: begin
                w_cyc_nxt = w_cyc_inc;
                if (MemWrite) begin
                    if (w_addr_hit && w_data_hit) begin
                        if (w_last) begin
                            w_state_nxt = ST_PASSED;
                            w_terminal  = 1'b1;
                        end else begin
                            w_ptr_nxt = r_ptr + IDX_W'(1);
                        end
                    end else if (w_addr_hit) begin
                        w_state_nxt = ST_FAILED;
                        w_code_nxt  = CODE_MISMATCH;
                        w_fidx_nxt  = r_ptr;
                        w_terminal  = 1'b1;
                    end else if (STRICT_ORDER) begin
                        w_state_nxt = ST_FAILED;
                        w_code_nxt  = CODE_UNEXP;
                        w_fidx_nxt  = r_ptr;
                        w_terminal  = 1'b1;
                    end
                end
                if (!w_terminal && w_timeout) begin
                    w_state_nxt = ST_FAILED;
                    w_code_nxt  = CODE_TIMEOUT;
                    w_fidx_nxt  = w_ptr_nxt;
                end
            end
            default: begin
                if (Start) begin
                    w_ptr_nxt   = '0;
                    w_cyc_nxt   = '0;
                    w_code_nxt  = CODE_NONE;
                    w_fidx_nxt  = '0;
                    w_count_nxt = w_count_clamp;
                    w_state_nxt = (w_count_clamp == '0) ? ST_PASSED : ST_ARMED;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (NRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer, latched count, cycle counter and failure report registers
    always_ff @(posedge CLK) begin
        if (NRESET) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_cyc   <= '0;
            r_code  <= CODE_NONE;
            r_fidx  <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_cyc   <= w_cyc_nxt;
            r_code  <= w_code_nxt;
            r_fidx  <= w_fidx_nxt;
        end
    end

    // Expected-store table; frozen while a check is in progress
    always_ff @(posedge CLK) begin
        if (NRESET) begin
            for (int unsigned i = 0; i < N_CHECKS; i++) begin
                r_exp_addr[i] <= '0;
                r_exp_data[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_exp_addr[Cfg_Idx] <= Cfg_Addr;
            r_exp_data[Cfg_Idx] <= Cfg_Data;
        end
    end

    // Status outputs decoded from registered state
    assign Busy        = (r_state == ST_ARMED);
    assign Done        = (r_state == ST_PASSED) || (r_state == ST_FAILED);
    assign Pass        = (r_state == ST_PASSED);
    assign Fail        = (r_state == ST_FAILED);
    assign Fail_Code   = r_code;
    assign Fail_Index  = r_fidx;
    assign Cycle_Count = r_cyc;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: one strict-order and one lenient
// instance share the same stimulus, each with a 50-cycle timeout.
module tb_mem_write_checker;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          nreset;
    logic          start;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [IW:0]   cfg_count;
    logic          mem_write;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;

    logic          s_busy, s_done, s_pass, s_fail;
    logic [1:0]    s_code;
    logic [IW-1:0] s_idx;
    logic [31:0]   s_cyc;
    logic          l_busy, l_done, l_pass, l_fail;
    logic [1:0]    l_code;
    logic [IW-1:0] l_idx;
    logic [31:0]   l_cyc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .N_CHECKS(4), .TIMEOUT_CYCLES(50), .STRICT_ORDER(1'b1)
    ) dut_s (
        .CLK(clk), .NRESET(nreset), .Start(start), .Cfg_WE(cfg_we), .Cfg_Idx(cfg_idx),
        .Cfg_Addr(cfg_addr), .Cfg_Data(cfg_data), .Cfg_Count(cfg_count),
        .MemWrite(mem_write), .Address(address), .Write_Data(write_data),
        .Busy(s_busy), .Done(s_done), .Pass(s_pass), .Fail(s_fail),
        .Fail_Code(s_code), .Fail_Index(s_idx), .Cycle_Count(s_cyc)
    );

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .N_CHECKS(4), .TIMEOUT_CYCLES(50), .STRICT_ORDER(1'b0)
    ) dut_l (
        .CLK(clk), .NRESET(nreset), .Start(start), .Cfg_WE(cfg_we), .Cfg_Idx(cfg_idx),
        .Cfg_Addr(cfg_addr), .Cfg_Data(cfg_data), .Cfg_Count(cfg_count),
        .MemWrite(mem_write), .Address(address), .Write_Data(write_data),
        .Busy(l_busy), .Done(l_done), .Pass(l_pass), .Fail(l_fail),
        .Fail_Code(l_code), .Fail_Index(l_idx), .Cycle_Count(l_cyc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [IW-1:0] i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [IW:0] n);
        start = 1'b1; cfg_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_write = 1'b1; address = a; write_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        nreset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0;
        cfg_data = '0; cfg_count = '0; mem_write = 1'b0; address = '0; write_data = '0;
        tick();
        nreset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_pass", 32'(l_pass), 0);
        chk("rst_fail", 32'(l_fail), 0);
        chk("rst_code", 32'(s_code), 0);
        chk("rst_cyc",  s_cyc, 0);

        // Single matching store
        cfg_write(2'd0, 32'd100, 32'd7);
        arm(3'd1);
        chk("arm_busy", 32'(s_busy), 1);
        chk("arm_done", 32'(s_done), 0);
        store(32'd100, 32'd7);
        chk("one_pass_s", 32'(s_pass), 1);
        chk("one_pass_l", 32'(l_pass), 1);
        chk("one_done", 32'(s_done), 1);
        chk("one_busy", 32'(s_busy), 0);
        chk("one_code", 32'(s_code), 0);
        chk("one_cyc",  s_cyc, 1);

        // Data mismatch on the awaited address
        arm(3'd1);
        store(32'd100, 32'd8);
        chk("mis_fail", 32'(s_fail), 1);
        chk("mis_pass", 32'(l_pass), 0);
        chk("mis_code", 32'(l_code), 1);
        chk("mis_idx",  32'(l_idx), 0);

        // Out-of-order store: strict fails, lenient ignores it and completes
        cfg_write(2'd0, 32'd80, 32'd1);
        cfg_write(2'd1, 32'd84, 32'd2);
        cfg_write(2'd2, 32'd100, 32'd7);
        arm(3'd3);
        store(32'd80, 32'd1);
        store(32'd100, 32'd7);
        chk("ord_s_fail", 32'(s_fail), 1);
        chk("ord_s_code", 32'(s_code), 2);
        chk("ord_s_idx",  32'(s_idx), 1);
        chk("ord_l_busy", 32'(l_busy), 1);
        store(32'd84, 32'd2);
        store(32'd100, 32'd7);
        chk("ord_l_pass", 32'(l_pass), 1);
        chk("ord_l_cyc",  l_cyc, 4);
        chk("ord_s_hold", 32'(s_code), 2);

        // Timeout with no stores
        arm(3'd1);
        idle(49);
        chk("to_busy49", 32'(s_busy), 1);
        chk("to_cyc49",  s_cyc, 49);
        tick();
        chk("to_fail", 32'(s_fail), 1);
        chk("to_code", 32'(l_code), 3);
        chk("to_idx",  32'(s_idx), 0);
        chk("to_cyc",  s_cyc, 50);
        idle(3);
        chk("to_frozen", l_cyc, 50);

        // Matching store on the timeout cycle wins
        arm(3'd1);
        idle(49);
        store(32'd80, 32'd1);
        chk("tow_pass", 32'(s_pass), 1);
        chk("tow_code", 32'(s_code), 0);
        chk("tow_cyc",  l_cyc, 50);

        // Table writes ignored while armed, then reset mid-check
        arm(3'd3);
        cfg_write(2'd0, 32'd80, 32'd55);
        store(32'd80, 32'd1);
        chk("we_busy", 32'(s_busy), 1);
        chk("we_fail", 32'(s_fail), 0);
        nreset = 1'b1;
        tick();
        nreset = 1'b0;
        chk("mrst_busy", 32'(s_busy), 0);
        chk("mrst_done", 32'(l_done), 0);
        chk("mrst_fail", 32'(s_fail), 0);
        chk("mrst_cyc",  s_cyc, 0);

        // Table cleared by reset: a zero store matches entry 0
        arm(3'd1);
        store(32'd0, 32'd0);
        chk("clr_pass", 32'(s_pass), 1);

        // Zero count passes straight away
        arm(3'd0);
        chk("z_pass", 32'(s_pass), 1);
        chk("z_busy", 32'(l_busy), 0);
        chk("z_cyc",  s_cyc, 0);

        // Count above the table depth clamps to four entries
        arm(3'd7);
        store(32'd0, 32'd0);
        store(32'd0, 32'd0);
        store(32'd0, 32'd0);
        chk("clamp_busy3", 32'(s_busy), 1);
        store(32'd0, 32'd0);
        chk("clamp_pass", 32'(s_pass), 1);
        chk("clamp_cyc",  l_cyc, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
